mycpu_mem_stage: RTL

//  Memory-access stage located directly after the EX stage in the 5-stage pipeline.

---
 rtl/mycpu_mem_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mycpu_mem_stage.sv
// MEM stage: data-SRAM handshake, load extension, store strobes.
// Define MYCPU_MEM_ALIGN_CHECK_EN for misaligned-address exceptions.
module mycpu_mem_stage #(
  parameter int DEST_W     = 5,
  parameter bit STORE_WAIT = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [3:0]        ex_mem_op,
  input  logic [DEST_W-1:0] ex_dest,
  output logic              mem_allowin,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  input  logic              wb_allowin,
`ifdef MYCPU_MEM_ALIGN_CHECK_EN
  output logic              wb_adel,
  output logic              wb_ades,
`endif
  output logic              wb_valid,
  output logic [DEST_W-1:0] wb_dest,
  output logic [31:0]       wb_result
);

  typedef enum logic [1:0] {
    S_EMPTY, S_REQ, S_WAIT, S_READY
  } state_e;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_e            state_q, state_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [3:0]        op_q, op_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;

  logic ex_mem, ex_load, ex_store, ex_mis, accept;
  logic q_load, q_store, q_byte, q_half, q_word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  assign ex_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
  assign ex_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
  assign ex_mem   = ex_load | ex_store;

`ifdef MYCPU_MEM_ALIGN_CHECK_EN
  assign ex_mis =
    (((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) ||
      (ex_mem_op == OP_SH)) && ex_alu_result[0]) ||
    (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW)) &&
      (ex_alu_result[1:0] != 2'b00));
  assign wb_adel = wb_valid & adel_q;
  assign wb_ades = wb_valid & ades_q;
`else
  assign ex_mis = 1'b0;
`endif

  assign q_load  = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign q_store = (op_q >= OP_SB) && (op_q <= OP_SW);
  assign q_byte  = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
  assign q_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign q_word  = (op_q == OP_LW) || (op_q == OP_SW);

  assign mem_allowin = (state_q == S_EMPTY) ||
                       ((state_q == S_READY) && wb_allowin);
  assign accept      = ex_valid & mem_allowin;

  assign data_req  = (state_q == S_REQ);
  assign data_wr   = q_store;
  assign data_addr = res_q;
  assign wb_valid  = (state_q == S_READY);
  assign wb_dest   = dest_q;
  assign wb_result = res_q;

  always_comb begin
    data_size  = 2'd2;
    data_wstrb = 4'b0000;
    data_wdata = sdata_q;
    unique case (1'b1)
      q_byte: begin
        data_size = 2'd0;
        if (q_store) begin
          data_wstrb = 4'b0001 << res_q[1:0];
          data_wdata = {4{sdata_q[7:0]}};
        end
      end
      q_half: begin
        data_size = 2'd1;
        if (q_store) begin
          data_wstrb = res_q[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{sdata_q[15:0]}};
        end
      end
      q_word: begin
        if (q_store) data_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (res_q[1:0])
      2'd0:    ld_b = data_rdata[7:0];
      2'd1:    ld_b = data_rdata[15:8];
      2'd2:    ld_b = data_rdata[23:16];
      default: ld_b = data_rdata[31:24];
    endcase
    ld_h = res_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    unique case (op_q)
      OP_LB:   ld_fmt = {{24{ld_b[7]}}, ld_b};
      OP_LBU:  ld_fmt = {24'd0, ld_b};
      OP_LH:   ld_fmt = {{16{ld_h[15]}}, ld_h};
      OP_LHU:  ld_fmt = {16'd0, ld_h};
      default: ld_fmt = data_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    sdata_d = sdata_q;
    op_d    = op_q;
    dest_d  = dest_q;
    adel_d  = adel_q;
    ades_d  = ades_q;
    unique case (state_q)
      S_REQ: begin
        if (data_addr_ok)
          state_d = (q_load || STORE_WAIT) ? S_WAIT : S_READY;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d = S_READY;
          if (q_load) res_d = ld_fmt;
        end
      end
      S_READY: begin
        if (wb_allowin) state_d = S_EMPTY;
      end
      default: ;
    endcase
    // a new accept overrides the drain to EMPTY in the same cycle
    if (accept) begin
      res_d   = ex_alu_result;
      sdata_d = ex_store_data;
      op_d    = ex_mem_op;
      dest_d  = ex_mis ? '0 : ex_dest;
      adel_d  = ex_mis & ex_load;
      ades_d  = ex_mis & ex_store;
      state_d = (ex_mem && !ex_mis) ? S_REQ : S_READY;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_EMPTY;
      res_q   <= '0;
      sdata_q <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      sdata_q <= sdata_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
    end
  end

  wire unused_ok = &{1'b0, adel_q, ades_q};

endmodule
